// File: rtl/cmos_capture_ctrl.sv
// cmos_capture_ctrl: frame-capture sequencer between the camera pixel converter and the
// frame-buffer write port. Arms on cap_en_i, aligns to the VS rising edge, writes RGB565
// pixels into one of two ping-pong buffers, checks line/frame geometry and swaps buffers on
// good frames unless the display reader holds the target buffer.
// Ports:
//   pclk, rst                 clock, synchronous active-high reset
//   cap_en_i, single_shot_i   software control
//   vs_i, de_i, pix_vld_i     converter timing; pdata_i pixel data
//   rd_busy_i, rd_buf_i       display reader lock
//   wr_en_o/wr_addr_o/wr_data_o  registered frame-buffer write port (1-cycle latency)
//   buf_sel_o, last_buf_o     active and last completed buffer
//   frame_done_o, frame_err_o one-cycle pulses; line_err_o sticky; busy_o state != IDLE
module cmos_capture_ctrl #(
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned ADDR_W   = 21,
  parameter int unsigned BASE0    = 0,
  parameter int unsigned BASE1    = 786432
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              cap_en_i,
  input  logic              single_shot_i,
  input  logic              vs_i,
  input  logic              de_i,
  input  logic              pix_vld_i,
  input  logic [15:0]       pdata_i,
  input  logic              rd_busy_i,
  input  logic              rd_buf_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [15:0]       wr_data_o,
  output logic              buf_sel_o,
  output logic              last_buf_o,
  output logic              frame_done_o,
  output logic              frame_err_o,
  output logic              line_err_o,
  output logic              busy_o
);

  localparam int unsigned PixW  = $clog2(H_ACTIVE + 1);
  localparam int unsigned LineW = $clog2(V_ACTIVE + 1);
  localparam logic [PixW-1:0]   HMax  = PixW'(H_ACTIVE);
  localparam logic [LineW-1:0]  VLast = LineW'(V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] Base0 = ADDR_W'(BASE0);
  localparam logic [ADDR_W-1:0] Base1 = ADDR_W'(BASE1);

  typedef enum logic [1:0] {StIdle, StArm, StCapture, StDone} state_e;

  state_e              state_q, state_d;
  logic                vs_q, de_q;
  logic [PixW-1:0]     pix_cnt_q, pix_cnt_d;
  logic [LineW-1:0]    line_cnt_q, line_cnt_d;
  logic [ADDR_W-1:0]   offset_q, offset_d;
  logic                buf_sel_q, buf_sel_d;
  logic                last_buf_q, last_buf_d;
  logic                line_err_q, line_err_d;
  logic                long_chk_q, long_chk_d;   // in ARM right after DONE, no extra line yet
  logic                shot_hold_q, shot_hold_d; // single shot done; wait for cap_en_i low
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [15:0]         wr_data_q, wr_data_d;
  logic                frame_done_q, frame_done_d;
  logic                frame_err_q, frame_err_d;

  logic vs_rise, de_fall;
  assign vs_rise = vs_i & ~vs_q;
  assign de_fall = de_q & ~de_i;

  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    line_cnt_d   = line_cnt_q;
    offset_d     = offset_q;
    buf_sel_d    = buf_sel_q;
    last_buf_d   = last_buf_q;
    line_err_d   = line_err_q;
    long_chk_d   = long_chk_q;
    shot_hold_d  = shot_hold_q & cap_en_i;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cap_en_i && !shot_hold_q) begin
          state_d    = StArm;
          long_chk_d = 1'b0;
        end
      end
      StArm: begin
        // A line ending before the next VS means the previous frame ran long.
        if (long_chk_q && de_fall) begin
          frame_err_d = 1'b1;
          long_chk_d  = 1'b0;
        end
        if (!cap_en_i) begin
          state_d    = StIdle;
          long_chk_d = 1'b0;
        end else if (vs_rise) begin
          state_d    = StCapture;
          pix_cnt_d  = '0;
          line_cnt_d = '0;
          offset_d   = '0;
          line_err_d = 1'b0;
          long_chk_d = 1'b0;
        end
      end
      StCapture: begin
        if (pix_vld_i && de_i) begin
          if (pix_cnt_q < HMax) begin
            wr_en_d   = 1'b1;
            wr_addr_d = (buf_sel_q ? Base1 : Base0) + offset_q;
            wr_data_d = pdata_i;
            offset_d  = offset_q + 1'b1;
            pix_cnt_d = pix_cnt_q + 1'b1;
          end else begin
            line_err_d = 1'b1;
          end
        end
        if (de_fall) begin
          if (pix_cnt_q != HMax) line_err_d = 1'b1;
          pix_cnt_d  = '0;
          line_cnt_d = line_cnt_q + 1'b1;
          if (line_cnt_q == VLast) state_d = StDone;
        end
        // Short frame: restart the same buffer. Ignored if de_fall just completed the frame.
        if (vs_rise && (state_d != StDone)) begin
          frame_err_d = 1'b1;
          pix_cnt_d   = '0;
          line_cnt_d  = '0;
          offset_d    = '0;
        end
      end
      StDone: begin
        frame_done_d = 1'b1;
        last_buf_d   = buf_sel_q;
        // Reader lock: keep overwriting the current buffer if the reader owns the other.
        if (!(rd_busy_i && (rd_buf_i == ~buf_sel_q))) buf_sel_d = ~buf_sel_q;
        if (single_shot_i || !cap_en_i) begin
          state_d     = StIdle;
          shot_hold_d = single_shot_i & cap_en_i;
        end else begin
          state_d    = StArm;
          long_chk_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q      <= StIdle;
      vs_q         <= 1'b0;
      de_q         <= 1'b0;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      offset_q     <= '0;
      buf_sel_q    <= 1'b0;
      last_buf_q   <= 1'b0;
      line_err_q   <= 1'b0;
      long_chk_q   <= 1'b0;
      shot_hold_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_q         <= vs_i;
      de_q         <= de_i;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      offset_q     <= offset_d;
      buf_sel_q    <= buf_sel_d;
      last_buf_q   <= last_buf_d;
      line_err_q   <= line_err_d;
      long_chk_q   <= long_chk_d;
      shot_hold_q  <= shot_hold_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign buf_sel_o    = buf_sel_q;
  assign last_buf_o   = last_buf_q;
  assign frame_done_o = frame_done_q;
  assign frame_err_o  = frame_err_q;
  assign line_err_o   = line_err_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_cmos_capture_ctrl.sv
// Scoreboard bench for cmos_capture_ctrl with a 4x2 geometry.
module tb_cmos_capture_ctrl;

  localparam int unsigned AW = 21;
  localparam int unsigned B1 = 786432;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  typedef struct packed {
    logic is_done;
    logic buf_sel;
    logic last_buf;
  } evt_t;

  logic          pclk = 1'b0;
  logic          rst, cap_en_i, single_shot_i, vs_i, de_i, pix_vld_i, rd_busy_i, rd_buf_i;
  logic [15:0]   pdata_i;
  logic          wr_en_o, buf_sel_o, last_buf_o, frame_done_o, frame_err_o, line_err_o, busy_o;
  logic [AW-1:0] wr_addr_o;
  logic [15:0]   wr_data_o;

  wr_t  exp_wr_q[$];
  evt_t exp_evt_q[$];
  wr_t  mon_wr;
  evt_t mon_evt;
  int   total = 0;
  int   bad = 0;
  logic [15:0] seed = 16'h1001;

  always #5 pclk = ~pclk;

  cmos_capture_ctrl #(
    .H_ACTIVE (4),
    .V_ACTIVE (2),
    .ADDR_W   (AW),
    .BASE0    (0),
    .BASE1    (B1)
  ) dut (
    .pclk          (pclk),
    .rst           (rst),
    .cap_en_i      (cap_en_i),
    .single_shot_i (single_shot_i),
    .vs_i          (vs_i),
    .de_i          (de_i),
    .pix_vld_i     (pix_vld_i),
    .pdata_i       (pdata_i),
    .rd_busy_i     (rd_busy_i),
    .rd_buf_i      (rd_buf_i),
    .wr_en_o       (wr_en_o),
    .wr_addr_o     (wr_addr_o),
    .wr_data_o     (wr_data_o),
    .buf_sel_o     (buf_sel_o),
    .last_buf_o    (last_buf_o),
    .frame_done_o  (frame_done_o),
    .frame_err_o   (frame_err_o),
    .line_err_o    (line_err_o),
    .busy_o        (busy_o)
  );

  // Monitor: pops the scoreboard whenever the DUT presents a write or a pulse.
  always @(negedge pclk) begin
    if (wr_en_o) begin
      total++;
      if (exp_wr_q.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected: got addr=%0d data=%h, expected no write", wr_addr_o,
                 wr_data_o);
      end else begin
        mon_wr = exp_wr_q.pop_front();
        if (wr_addr_o !== mon_wr.addr || wr_data_o !== mon_wr.data) begin
          bad++;
          $display("FAIL wr: got addr=%0d data=%h, expected addr=%0d data=%h", wr_addr_o,
                   wr_data_o, mon_wr.addr, mon_wr.data);
        end
      end
    end
    if (frame_done_o || frame_err_o) begin
      total++;
      if (exp_evt_q.size() == 0) begin
        bad++;
        $display("FAIL evt_unexpected: got done=%b err=%b, expected none", frame_done_o,
                 frame_err_o);
      end else begin
        mon_evt = exp_evt_q.pop_front();
        if (mon_evt.is_done) begin
          if (!frame_done_o || frame_err_o || buf_sel_o !== mon_evt.buf_sel ||
              last_buf_o !== mon_evt.last_buf) begin
            bad++;
            $display("FAIL frame_done: got done=%b err=%b buf_sel=%b last_buf=%b, expected done=1 err=0 buf_sel=%b last_buf=%b",
                     frame_done_o, frame_err_o, buf_sel_o, last_buf_o, mon_evt.buf_sel,
                     mon_evt.last_buf);
          end
        end else if (!frame_err_o || frame_done_o) begin
          bad++;
          $display("FAIL frame_err: got done=%b err=%b, expected done=0 err=1", frame_done_o,
                   frame_err_o);
        end
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic vsync();
    vs_i = 1'b1;
    repeat (2) tick();
    vs_i = 1'b0;
    repeat (2) tick();
  endtask

  // Sends one line of npix pixels; the first nwr are expected at first_addr onward.
  task automatic send_line(input int npix, input int unsigned first_addr, input int nwr);
    wr_t w;
    de_i = 1'b1;
    for (int i = 0; i < npix; i++) begin
      pix_vld_i = 1'b1;
      pdata_i   = seed;
      if (i < nwr) begin
        w.addr = AW'(first_addr + i);
        w.data = seed;
        exp_wr_q.push_back(w);
      end
      seed = seed + 16'h1357;
      tick();
    end
    pix_vld_i = 1'b0;
    tick();
    de_i = 1'b0;
    repeat (4) tick();
  endtask

  task automatic expect_done(input logic bs, input logic lb);
    evt_t e;
    e.is_done  = 1'b1;
    e.buf_sel  = bs;
    e.last_buf = lb;
    exp_evt_q.push_back(e);
  endtask

  task automatic expect_err();
    evt_t e;
    e = '0;
    exp_evt_q.push_back(e);
  endtask

  // Full 2-line frame into the buffer starting at base.
  task automatic good_frame(input int unsigned base, input logic bs, input logic lb);
    vsync();
    send_line(4, base, 4);
    expect_done(bs, lb);
    send_line(4, base + 4, 4);
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({wr_en_o, wr_addr_o, wr_data_o, buf_sel_o, last_buf_o, frame_done_o,
                frame_err_o, line_err_o, busy_o});
  endfunction

  initial begin
    rst = 1'b1;
    cap_en_i = 1'b0;
    single_shot_i = 1'b0;
    vs_i = 1'b0;
    de_i = 1'b0;
    pix_vld_i = 1'b0;
    pdata_i = '0;
    rd_busy_i = 1'b0;
    rd_buf_i = 1'b0;
    repeat (3) tick();
    check("reset_outputs", out_vec(), 64'd0);
    rst = 1'b0;
    repeat (2) tick();
    check("idle_not_busy", 64'(busy_o), 64'd0);
    cap_en_i = 1'b1;
    repeat (2) tick();
    check("armed_busy", 64'(busy_o), 64'd1);

    // Ping-pong: buffer 0 then buffer 1.
    good_frame(0, 1'b1, 1'b0);
    check("swap_to_1", 64'({buf_sel_o, last_buf_o, line_err_o}), 64'b100);
    good_frame(B1, 1'b0, 1'b1);
    check("swap_to_0", 64'(buf_sel_o), 64'd0);

    // Short frame: error pulse, then buffer 0 restarts at address 0.
    vsync();
    send_line(4, 0, 4);
    expect_err();
    good_frame(0, 1'b1, 1'b0);

    // Reader lock: reader holds buffer 0, so buffer 1 is rewritten.
    rd_busy_i = 1'b1;
    rd_buf_i  = 1'b0;
    good_frame(B1, 1'b1, 1'b1);
    check("lock_hold", 64'(buf_sel_o), 64'd1);
    rd_busy_i = 1'b0;
    good_frame(B1, 1'b0, 1'b1);

    // Long line: only 4 of 6 written, sticky line_err.
    vsync();
    send_line(6, 0, 4);
    check("line_err_long", 64'(line_err_o), 64'd1);
    expect_done(1'b1, 1'b0);
    send_line(4, 4, 4);
    check("line_err_sticky", 64'(line_err_o), 64'd1);

    // Extra lines after DONE: one frame_err, nothing written.
    expect_err();
    send_line(4, 0, 0);
    send_line(4, 0, 0);
    vsync();
    check("line_err_cleared", 64'(line_err_o), 64'd0);
    send_line(3, B1, 3);
    check("line_err_short", 64'(line_err_o), 64'd1);
    expect_done(1'b0, 1'b1);
    send_line(4, B1 + 3, 4);

    // Single shot: back to IDLE, later frames ignored until cap_en toggles.
    single_shot_i = 1'b1;
    good_frame(0, 1'b1, 1'b0);
    check("single_shot_idle", 64'(busy_o), 64'd0);
    vsync();
    send_line(4, 0, 0);
    send_line(4, 0, 0);
    check("single_shot_stays_idle", 64'(busy_o), 64'd0);
    single_shot_i = 1'b0;
    cap_en_i = 1'b0;
    tick();
    cap_en_i = 1'b1;
    repeat (2) tick();
    check("rearm_busy", 64'(busy_o), 64'd1);
    good_frame(B1, 1'b0, 1'b1);

    // Reset in the middle of line 1 (buffer 0 active).
    vsync();
    de_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pix_vld_i = 1'b1;
      pdata_i   = seed;
      exp_wr_q.push_back(wr_t'({AW'(i), seed}));
      seed = seed + 16'h1357;
      tick();
    end
    pix_vld_i = 1'b0;
    rst = 1'b1;
    tick();
    check("midframe_reset_outputs", out_vec(), 64'd0);
    rst = 1'b0;
    de_i = 1'b0;
    repeat (2) tick();
    send_line(4, 0, 0);
    good_frame(0, 1'b1, 1'b0);

    repeat (5) tick();
    check("wr_queue_empty", 64'(exp_wr_q.size()), 64'd0);
    check("evt_queue_empty", 64'(exp_evt_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
